// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory op codes, FSM states,
// access sizing and the latched-access / write-back bundles.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Access width implied by the op code; unknown ops are treated as word accesses
  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_load;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        reg_write;
  } wb_bundle_t;

endpackage

// File: rtl/mem_stage_align.sv
// Big-endian lane logic: byte enables, store-data replication and misalign
// detect for the outgoing access; lane extraction and extension for loads.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  st_op,
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic        misalign_c,
  input  logic [5:0]  ld_op,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;

  // Outgoing access: byte 0 lives in bits 31:24
  always_comb begin
    be_c       = 4'b1111;
    wdata_c    = st_data;
    misalign_c = 1'b0;
    case (op_size(st_op))
      SZ_BYTE: begin
        be_c    = 4'b1000 >> st_addr;
        wdata_c = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be_c       = st_addr[1] ? 4'b0011 : 4'b1100;
        wdata_c    = {2{st_data[15:0]}};
        misalign_c = st_addr[0];
      end
      default: begin
        be_c       = 4'b1111;
        misalign_c = |st_addr;
      end
    endcase
  end

  // Returning load data: pick the addressed lane, then extend
  always_comb begin
    case (ld_addr)
      2'd0:    byte_lane = rdata[31:24];
      2'd1:    byte_lane = rdata[23:16];
      2'd2:    byte_lane = rdata[15:8];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = ld_addr[1] ? rdata[15:0] : rdata[31:16];
    sext      = (ld_op == OP_LB) || (ld_op == OP_LH);
    case (op_size(ld_op))
      SZ_BYTE: load_data_c = {{24{sext & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data_c = {{16{sext & half_lane[15]}}, half_lane};
      default: load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: passes ALU results to WB, runs loads/stores over a req/ack data
// port with a bounded wait, and stalls EXE while an access is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_OUT,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        err_OUT
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  mem_req_t      lat, lat_n;
  wb_bundle_t    wb_q, wb_n;
  logic          req_n, we_n, stall_n, err_n;
  logic [31:0]   addr_n, wdata_n;
  logic [3:0]    be_n;

  logic          in_valid, is_mem;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c, load_data_c;
  logic          misalign_c;

  mem_align u_align (
    .st_op       (ALU_Control1_IN),
    .st_addr     (ALU_result1_IN[1:0]),
    .st_data     (MemWriteData1_IN),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .misalign_c  (misalign_c),
    .ld_op       (lat.op),
    .ld_addr     (lat.addr[1:0]),
    .rdata       (dmem_rdata),
    .load_data_c (load_data_c)
  );

  assign in_valid = (Instr1_PC_IN != 32'd0);
  assign is_mem   = MemRead1_IN | MemWrite1_IN;
  assign cnt_inc  = cnt + CNT_W'(1);

  // Next-state and next-output logic; WB defaults to a bubble each cycle
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    lat_n          = lat;
    req_n          = 1'b0;
    we_n           = dmem_we;
    addr_n         = dmem_addr;
    be_n           = dmem_be;
    wdata_n        = dmem_wdata;
    stall_n        = 1'b0;
    err_n          = 1'b0;
    wb_n           = wb_q;
    wb_n.pc        = 32'd0;
    wb_n.reg_write = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_n.instr     = Instr1_IN;
            wb_n.pc        = Instr1_PC_IN;
            wb_n.wdata     = ALU_result1_IN;
            wb_n.rd        = WriteRegister1_IN;
            wb_n.reg_write = RegWrite1_IN;
          end else if (misalign_c) begin
            err_n = 1'b1;
          end else begin
            lat_n.instr     = Instr1_IN;
            lat_n.pc        = Instr1_PC_IN;
            lat_n.addr      = ALU_result1_IN;
            lat_n.op        = ALU_Control1_IN;
            lat_n.rd        = WriteRegister1_IN;
            lat_n.reg_write = RegWrite1_IN;
            lat_n.is_load   = ~MemWrite1_IN;
            req_n           = 1'b1;
            we_n            = MemWrite1_IN;
            addr_n          = {ALU_result1_IN[31:2], 2'b00};
            be_n            = be_c;
            wdata_n         = wdata_c;
            cnt_n           = '0;
            state_n         = WAIT;
          end
        end
      end
      WAIT: begin
        req_n = 1'b1;
        if (dmem_ack) begin
          req_n          = 1'b0;
          state_n        = IDLE;
          wb_n.instr     = lat.instr;
          wb_n.pc        = lat.pc;
          wb_n.rd        = lat.rd;
          wb_n.wdata     = lat.is_load ? load_data_c : lat.addr;
          wb_n.reg_write = lat.is_load & lat.reg_write;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = IDLE;
    endcase

    stall_n = (state_n == WAIT);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      lat        <= '0;
      wb_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      stall_OUT  <= 1'b0;
      err_OUT    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lat        <= lat_n;
      wb_q       <= wb_n;
      dmem_req   <= req_n;
      dmem_we    <= we_n;
      dmem_addr  <= addr_n;
      dmem_be    <= be_n;
      dmem_wdata <= wdata_n;
      stall_OUT  <= stall_n;
      err_OUT    <= err_n;
    end
  end

  assign Instr1_OUT         = wb_q.instr;
  assign Instr1_PC_OUT      = wb_q.pc;
  assign WriteData1_OUT     = wb_q.wdata;
  assign WriteRegister1_OUT = wb_q.rd;
  assign RegWrite1_OUT      = wb_q.reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed EXE instructions and a scripted
// data-memory responder; a monitor checks every WB bundle against the queue.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_OUT, RegWrite1_OUT, err_OUT;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT;
  logic [4:0]  WriteRegister1_OUT;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .MemRead1_IN(MemRead1_IN),
    .MemWrite1_IN(MemWrite1_IN),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_OUT(stall_OUT),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .err_OUT(err_OUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // WB monitor: every non-bubble WB bundle must match the oldest expectation
  always @(negedge CLK) begin
    if (RESET === 1'b1 && Instr1_PC_OUT != 32'd0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected actual_pc=%h required=none", Instr1_PC_OUT);
      end else begin
        e = sb.pop_front();
        chk("wb_pc", Instr1_PC_OUT, e.pc);
        chk("wb_regwrite", 32'(RegWrite1_OUT), 32'(e.rw));
        chk("wb_reg", 32'(WriteRegister1_OUT), 32'(e.rd));
        if (e.rw) chk("wb_data", WriteData1_OUT, e.wd);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rw);
    exp_t x;
    x.pc = pc; x.wd = wd; x.rd = rd; x.rw = rw;
    sb.push_back(x);
  endtask

  // Present one instruction for one capture edge, then a bubble
  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] data, input logic rw, input logic [5:0] op,
                       input logic mr, input logic mw);
    @(negedge CLK);
    Instr1_IN = 32'hC000_0000 | pc; Instr1_PC_IN = pc; ALU_result1_IN = alu;
    WriteRegister1_IN = rd; MemWriteData1_IN = data; RegWrite1_IN = rw;
    ALU_Control1_IN = op; MemRead1_IN = mr; MemWrite1_IN = mw;
    @(negedge CLK);
    Instr1_PC_IN = 32'd0; RegWrite1_IN = 1'b0; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
  endtask

  // Memory responder: checks the request, acks in WAIT cycle ack_at (0 = never)
  task automatic mem_run(input logic exp_we, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input int ack_at, input logic [31:0] rdata, input int exp_stall);
    int stall_cnt = 0;
    chk("req_high", 32'(dmem_req), 32'd1);
    chk("req_we", 32'(dmem_we), 32'(exp_we));
    chk("req_addr", dmem_addr, exp_addr);
    chk("req_be", 32'(dmem_be), 32'(exp_be));
    if (exp_we) chk("req_wdata", dmem_wdata, exp_wdata);
    for (int k = 1; k <= 40; k++) begin
      if (!stall_OUT) break;
      stall_cnt++;
      dmem_ack   = (k == ack_at);
      dmem_rdata = rdata;
      @(negedge CLK);
      dmem_ack = 1'b0;
    end
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("req_dropped", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    RESET = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    Instr1_IN = 32'd0; Instr1_PC_IN = 32'd0; ALU_result1_IN = 32'd0;
    WriteRegister1_IN = 5'd0; MemWriteData1_IN = 32'd0; RegWrite1_IN = 1'b0;
    ALU_Control1_IN = 6'd0; MemRead1_IN = 1'b0; MemWrite1_IN = 1'b0;
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_OUT), 32'd0);
    chk("rst_pc", Instr1_PC_OUT, 32'd0);
    chk("rst_regwrite", 32'(RegWrite1_OUT), 32'd0);
    chk("rst_err", 32'(err_OUT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // ALU pass-through
    push(32'h400, 32'h12, 5'd5, 1'b1);
    issue(32'h400, 32'h12, 5'd5, 32'd0, 1'b1, 6'h01, 1'b0, 1'b0);
    chk("add_stall", 32'(stall_OUT), 32'd0);

    // Loads and stores across lanes and sizes
    push(32'h500, 32'hFFFF_FFF0, 5'd6, 1'b1);
    issue(32'h500, 32'h1003, 5'd6, 32'd0, 1'b1, OP_LB, 1'b1, 1'b0);
    mem_run(1'b0, 32'h1000, 4'b0001, 32'd0, 3, 32'h0000_00F0, 3);
    chk("lb_err", 32'(err_OUT), 32'd0);

    push(32'h504, 32'h0000_8001, 5'd7, 1'b1);
    issue(32'h504, 32'h1000, 5'd7, 32'd0, 1'b1, OP_LHU, 1'b1, 1'b0);
    mem_run(1'b0, 32'h1000, 4'b1100, 32'd0, 1, 32'h8001_2345, 1);

    push(32'h508, 32'd0, 5'd0, 1'b0);
    issue(32'h508, 32'h1002, 5'd0, 32'h0000_BEEF, 1'b0, OP_SH, 1'b0, 1'b1);
    mem_run(1'b1, 32'h1000, 4'b0011, 32'hBEEF_BEEF, 2, 32'd0, 2);

    push(32'h50C, 32'hFFFF_8001, 5'd8, 1'b1);
    issue(32'h50C, 32'h1002, 5'd8, 32'd0, 1'b1, OP_LH, 1'b1, 1'b0);
    mem_run(1'b0, 32'h1000, 4'b0011, 32'd0, 1, 32'h0000_8001, 1);

    push(32'h510, 32'h0000_00AB, 5'd9, 1'b1);
    issue(32'h510, 32'h1001, 5'd9, 32'd0, 1'b1, OP_LBU, 1'b1, 1'b0);
    mem_run(1'b0, 32'h1000, 4'b0100, 32'd0, 1, 32'h00AB_0000, 1);

    push(32'h514, 32'd0, 5'd0, 1'b0);
    issue(32'h514, 32'h1001, 5'd0, 32'h1234_565A, 1'b0, OP_SB, 1'b0, 1'b1);
    mem_run(1'b1, 32'h1000, 4'b0100, 32'h5A5A_5A5A, 1, 32'd0, 1);

    push(32'h518, 32'd0, 5'd0, 1'b0);
    issue(32'h518, 32'h1004, 5'd0, 32'hDEAD_BEEF, 1'b0, OP_SW, 1'b0, 1'b1);
    mem_run(1'b1, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 1, 32'd0, 1);

    push(32'h51C, 32'hCAFE_F00D, 5'd10, 1'b1);
    issue(32'h51C, 32'h1008, 5'd10, 32'd0, 1'b1, OP_LW, 1'b1, 1'b0);
    mem_run(1'b0, 32'h1008, 4'b1111, 32'd0, 1, 32'hCAFE_F00D, 1);

    // Misaligned word and half: error pulse, no request, bubble
    issue(32'h520, 32'h1002, 5'd11, 32'd0, 1'b1, OP_LW, 1'b1, 1'b0);
    chk("mis_lw_req", 32'(dmem_req), 32'd0);
    chk("mis_lw_err", 32'(err_OUT), 32'd1);
    chk("mis_lw_pc", Instr1_PC_OUT, 32'd0);
    chk("mis_lw_stall", 32'(stall_OUT), 32'd0);
    @(negedge CLK);
    chk("mis_lw_err_pulse", 32'(err_OUT), 32'd0);
    issue(32'h524, 32'h1001, 5'd0, 32'h1111, 1'b0, OP_SH, 1'b0, 1'b1);
    chk("mis_sh_req", 32'(dmem_req), 32'd0);
    chk("mis_sh_err", 32'(err_OUT), 32'd1);

    // Ack while idle does nothing
    @(negedge CLK);
    dmem_ack = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    dmem_ack = 1'b0;
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    chk("idle_ack_err", 32'(err_OUT), 32'd0);

    // Timeout after 16 WAIT cycles, then normal operation resumes
    issue(32'h600, 32'h2000, 5'd12, 32'd0, 1'b1, OP_LW, 1'b1, 1'b0);
    mem_run(1'b0, 32'h2000, 4'b1111, 32'd0, 0, 32'd0, 16);
    chk("to_err", 32'(err_OUT), 32'd1);
    chk("to_pc", Instr1_PC_OUT, 32'd0);
    @(negedge CLK);
    chk("to_err_pulse", 32'(err_OUT), 32'd0);
    push(32'h604, 32'h77, 5'd13, 1'b1);
    issue(32'h604, 32'h77, 5'd13, 32'd0, 1'b1, 6'h01, 1'b0, 1'b0);

    // Reset mid-WAIT discards the access
    issue(32'h700, 32'h3000, 5'd14, 32'd0, 1'b1, OP_LW, 1'b1, 1'b0);
    chk("rw_req_before", 32'(dmem_req), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_stall", 32'(stall_OUT), 32'd0);
    chk("rw_pc", Instr1_PC_OUT, 32'd0);
    chk("rw_regwrite", 32'(RegWrite1_OUT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge CLK);
    dmem_ack = 1'b0;
    @(negedge CLK);
    chk("rw_post_req", 32'(dmem_req), 32'd0);
    chk("rw_post_regwrite", 32'(RegWrite1_OUT), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Single-issue MEM pipeline stage between EXE and WB. It consumes EXE's registered outputs and performs loads/stores through a req/ack data-memory port, including big-endian byte/half extraction and sign extension. It stalls upstream while an access is outstanding and forwards a write-back bundle to WB. Non-memory instructions pass through with one register of latency.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting for dmem_ack before abort (counter width = clog2(TIMEOUT_CYCLES+1))

Ports:
CLK  in  1  clock, all state on posedge
RESET  in  1  asynchronous active-low reset
Instr1_IN  in  32  instruction from EXE [debug]
Instr1_PC_IN  in  32  PC from EXE; 0 = bubble
ALU_result1_IN  in  32  ALU result / effective address
WriteRegister1_IN  in  5  destination register
MemWriteData1_IN  in  32  store data, right-justified
RegWrite1_IN  in  1  instruction writes a register
ALU_Control1_IN  in  6  op code; selects memory access kind
MemRead1_IN  in  1  load
MemWrite1_IN  in  1  store
dmem_req  out  1  access request, held until ack or timeout
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address ({ALU_result[31:2],2'b00})
dmem_be  out  4  byte enables, be[3] = bits 31:24
dmem_wdata  out  32  store data replicated into lanes
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  access complete, sampled at posedge
stall_OUT  out  1  1 = EXE must hold its outputs
Instr1_OUT  out  32  instruction to WB [debug]
Instr1_PC_OUT  out  32  PC to WB; 0 = bubble
WriteData1_OUT  out  32  register write-back value
WriteRegister1_OUT  out  5  destination register
RegWrite1_OUT  out  1  WB performs a write
err_OUT  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (async, RESET=0): state IDLE, timeout counter 0, all outputs 0 (dmem_req=0, stall_OUT=0, Instr1_PC_OUT=0, RegWrite1_OUT=0, err_OUT=0).
- Input is valid only when Instr1_PC_IN != 0. Otherwise WB outputs become a bubble: PC=0, RegWrite=0.
- IDLE, valid and not (MemRead|MemWrite): WB outputs <= inputs, WriteData = ALU_result. One-cycle latency.
- IDLE, valid memory op:
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=0.
  - Misaligned: no request, bubble to WB, err_OUT=1 for one cycle, stay IDLE.
  - Aligned: latch op, address, data, register and PC. Assert dmem_req with we/be/wdata. Go to WAIT. WB outputs become a bubble.
- WAIT: stall_OUT=1 (registered, = state==WAIT). Inputs ignored; EXE holds them.
  - On dmem_ack: drop req; go IDLE.
    - Load: WriteData = extracted lane, sign- or zero-extended per op; RegWrite as latched.
    - Store: RegWrite=0, PC/Instr passed.
  - Timeout (counter reaches TIMEOUT_CYCLES without ack): drop req, bubble to WB, err_OUT pulse, go IDLE.
  - Counter clears on entry to WAIT.
- Lane mapping (big-endian):
  - Byte at addr[1:0]=0 → bits 31:24, be=4'b1000; addr[1:0]=3 → bits 7:0, be=4'b0001.
  - Half at addr[1]=0 → bits 31:16, be=4'b1100.
  - Word → be=4'b1111.
  - Store data: byte replicated to all 4 lanes, half replicated to both halves.
- dmem_ack while IDLE is ignored. Earliest completion: ack in the first WAIT cycle, so a load result appears at WB 2 edges after MEM capture.
- Reset mid-WAIT: req drops asynchronously and the access is discarded.

Decomposition:
- Shared package holds:
  - Op constants: LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B.
  - State encoding: IDLE, WAIT.
- One sub-module, mem_align: combinational be/wdata generation, load extraction/extension, and misalign detect.

Test Plan:
- ADD, PC=0x400, ALU=0x12, Reg 5 → next edge: WB PC=0x400, WriteData=0x12, RegWrite=1, stall 0.
- LB @0x1003, rdata=0x000000F0, ack on 3rd WAIT cycle → be=0001; WriteData=0xFFFFFFF0; stall high exactly 3 cycles.
- LHU @0x1000, rdata=0x8001_2345 → WriteData=0x00008001. SH @0x1002, data 0xBEEF → be=0011, wdata=0xBEEFBEEF, RegWrite=0.
- LW @0x1002 → no dmem_req, err_OUT one cycle, WB bubble (PC=0).
- LW, ack never arrives, TIMEOUT_CYCLES=16 → req drops after 16 WAIT cycles, err pulse, back IDLE, next ADD passes.
- RESET low during WAIT → dmem_req=0 and all outputs 0 immediately; a later ack causes no WB write.
